// File: rtl/blake2b_ctrl.sv
// Sequencing controller for a BLAKE2b-512 core: packs 64-bit host beats into
// 1024-bit blocks, issues init/next/final commands and captures the digest.
module blake2b_ctrl (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          msg_valid,
    output logic          msg_ready,
    input  logic [63:0]   msg_data,
    input  logic          msg_last,
    input  logic [3:0]    msg_bytes,
    output logic          core_init,
    output logic          core_next,
    output logic          core_final,
    output logic [1023:0] core_block,
    output logic [127:0]  core_length,
    input  logic          core_ready,
    input  logic [511:0]  core_digest,
    input  logic          core_digest_valid,
    output logic [511:0]  digest,
    output logic          digest_valid,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_FILL, S_PEND, S_ISSUE, S_WAIT, S_DGST
    } state_t;

    state_t            state_q;
    logic [15:0][63:0] blk_q;
    logic [3:0]        idx_q;
    logic [127:0]      count_q;
    logic              final_q;
    logic              settle_q;
    logic [511:0]      digest_q;
    logic              digest_valid_q;

    logic [3:0]        beat_bytes_d;
    logic [63:0]       beat_word_d;
    logic              terminator;

    // A last beat carries 0..8 bytes; anything above 8 is clamped.
    assign beat_bytes_d = !msg_last        ? 4'd8 :
                          (msg_bytes > 4'd8) ? 4'd8 : msg_bytes;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        beat_word_d = '0;
        for (int b = 0; b < 8; b++) begin
            beat_word_d[8*b +: 8] = (4'(b) < beat_bytes_d) ? msg_data[8*b +: 8] : 8'h00;
        end
    end

    assign terminator = msg_valid && msg_last && (msg_bytes == 4'd0);

    // Commands are decoded in the cycle core_ready is seen so they never fire on a busy core.
    assign msg_ready    = (state_q == S_FILL) || ((state_q == S_PEND) && terminator);
    assign core_init    = (state_q == S_IDLE)  && msg_valid && core_ready;
    assign core_next    = (state_q == S_ISSUE) && core_ready && !final_q;
    assign core_final   = (state_q == S_ISSUE) && core_ready &&  final_q;
    assign core_block   = blk_q;
    assign core_length  = count_q;
    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;
    assign busy         = (state_q != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            // NOTE: the block buffer drives core_block directly, so it is reset like any output.
            blk_q          <= '0;
            idx_q          <= '0;
            count_q        <= '0;
            final_q        <= 1'b0;
            settle_q       <= 1'b0;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (msg_valid && core_ready) begin
                        blk_q          <= '0;
                        idx_q          <= '0;
                        count_q        <= '0;
                        final_q        <= 1'b0;
                        digest_valid_q <= 1'b0;
                        settle_q       <= 1'b1;
                        state_q        <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (settle_q) begin
                        settle_q <= 1'b0;
                    end else if (core_ready) begin
                        state_q <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (msg_valid) begin
                        blk_q[idx_q] <= beat_word_d;
                        count_q      <= count_q + 128'(beat_bytes_d);
                        if (msg_last) begin
                            final_q <= 1'b1;
                            state_q <= S_ISSUE;
                        end else if (idx_q == 4'd15) begin
                            state_q <= S_PEND;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                S_PEND: begin
                    // A full block is final only if the next beat is an empty terminator.
                    if (terminator) begin
                        final_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end else if (msg_valid) begin
                        final_q <= 1'b0;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (core_ready) begin
                        settle_q <= 1'b1;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (settle_q) begin
                        settle_q <= 1'b0;
                    end else if (core_ready) begin
                        if (final_q) begin
                            state_q <= S_DGST;
                        end else begin
                            blk_q   <= '0;
                            idx_q   <= '0;
                            state_q <= S_FILL;
                        end
                    end
                end
                S_DGST: begin
                    if (core_digest_valid) begin
                        digest_q       <= core_digest;
                        digest_valid_q <= 1'b1;
                        state_q        <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blake2b_ctrl.sv
// Scoreboard bench for blake2b_ctrl: stimulus queues expected core commands and
// digests, a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_blake2b_ctrl;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          msg_valid = 1'b0;
    logic          msg_ready;
    logic [63:0]   msg_data = '0;
    logic          msg_last = 1'b0;
    logic [3:0]    msg_bytes = '0;
    logic          core_init, core_next, core_final;
    logic [1023:0] core_block;
    logic [127:0]  core_length;
    logic          core_ready = 1'b1;
    logic [511:0]  core_digest = '0;
    logic          core_digest_valid = 1'b0;
    logic [511:0]  digest;
    logic          digest_valid;
    logic          busy;

    blake2b_ctrl dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .msg_valid         (msg_valid),
        .msg_ready         (msg_ready),
        .msg_data          (msg_data),
        .msg_last          (msg_last),
        .msg_bytes         (msg_bytes),
        .core_init         (core_init),
        .core_next         (core_next),
        .core_final        (core_final),
        .core_block        (core_block),
        .core_length       (core_length),
        .core_ready        (core_ready),
        .core_digest       (core_digest),
        .core_digest_valid (core_digest_valid),
        .digest            (digest),
        .digest_valid      (digest_valid),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_INIT = 0, EV_NEXT = 1, EV_FINAL = 2, EV_DIG = 3} ev_kind_t;
    typedef struct {
        ev_kind_t      kind;
        logic [127:0]  length;
        logic [1023:0] block;
        logic [511:0]  dig;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    localparam logic [63:0] FLAMINGO = 64'h6f676e696d616c66;

    int            stall_next = 0;
    logic          in_stall   = 1'b0;
    logic [1023:0] stall_block = '0;
    logic          dv_prev    = 1'b0;
    logic          cdv_prev   = 1'b0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_block(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        for (int k = 0; k < 16; k++)
            check($sformatf("%s word%0d", name, k), 512'(act[64*k +: 64]), 512'(exp[64*k +: 64]));
    endtask

    function automatic logic [63:0] pat_word(input int j);
        logic [63:0] w;
        for (int b = 0; b < 8; b++) w[8*b +: 8] = 8'(j * 8 + b);
        return w;
    endfunction

    function automatic logic [1023:0] full_block();
        logic [1023:0] blk;
        for (int k = 0; k < 16; k++) blk[64*k +: 64] = pat_word(k);
        return blk;
    endfunction

    // Digest the core model returns for a given final length.
    function automatic logic [511:0] dig_of(input logic [127:0] len);
        return {len, ~len, len ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0,
                128'hdeadbeefcafef00d0123456789abcdef};
    endfunction

    task automatic push_ev(input ev_kind_t kind, input logic [127:0] len, input logic [1023:0] blk);
        ev_t e;
        e.kind   = kind;
        e.length = len;
        e.block  = blk;
        e.dig    = dig_of(len);
        exp_q.push_back(e);
    endtask

    // Core model: goes busy after each command, returns a digest after a final.
    initial begin
        logic         fin;
        logic [127:0] len;
        int           n;
        logic         stalling;
        forever begin
            @(negedge clk);
            if (reset_n && (core_init || core_next || core_final)) begin
                fin      = core_final;
                len      = core_length;
                stalling = core_next && (stall_next > 0);
                n        = stalling ? stall_next : 3;
                if (stalling) stall_next = 0;
                @(posedge clk); #1;
                core_ready = 1'b0;
                in_stall   = stalling;
                repeat (n) @(posedge clk);
                #1;
                core_ready = 1'b1;
                in_stall   = 1'b0;
                if (fin) begin
                    @(posedge clk); #1;
                    core_digest       = dig_of(len);
                    core_digest_valid = 1'b1;
                    @(posedge clk); #1;
                    core_digest_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every command pulse and digest_valid rise against the queue.
    always @(negedge clk) begin
        int  npulse;
        int  kind;
        ev_t e;
        npulse = int'(core_init) + int'(core_next) + int'(core_final);
        if (npulse > 0) begin
            check("cmd one-hot", 512'(npulse == 1), 512'(1));
            check("cmd needs core_ready", 512'(core_ready), 512'(1));
            kind = core_init ? EV_INIT : (core_next ? EV_NEXT : EV_FINAL);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected cmd: got kind %0d expected none", kind);
            end else begin
                e = exp_q.pop_front();
                check("cmd kind", 512'(kind), 512'(int'(e.kind)));
                if (e.kind != EV_INIT) begin
                    check("core_length", 512'(core_length), 512'(e.length));
                    check_block("core_block", core_block, e.block);
                end
                if (e.kind == EV_NEXT) stall_block = e.block;
            end
        end
        if (in_stall) begin
            check("stall msg_ready", 512'(msg_ready), 512'(0));
            check("stall no cmd", 512'(npulse), 512'(0));
            check_block("stall core_block", core_block, stall_block);
        end
        if (digest_valid && !dv_prev) begin
            check("digest latency", 512'(cdv_prev), 512'(1));
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected digest_valid: got 1 expected 0");
            end else begin
                e = exp_q.pop_front();
                check("digest event kind", 512'(int'(e.kind)), 512'(int'(EV_DIG)));
                check("digest", digest, e.dig);
            end
        end
        dv_prev  = digest_valid;
        cdv_prev = core_digest_valid;
    end

    task automatic send_beat(input logic [63:0] data, input logic last, input logic [3:0] nbytes);
        logic acc;
        int   t;
        msg_valid = 1'b1;
        msg_data  = data;
        msg_last  = last;
        msg_bytes = nbytes;
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 300) begin
            @(negedge clk);
            acc = msg_ready;
            @(posedge clk); #1;
            t++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL beat handshake: got no msg_ready expected accept within 300 cycles");
        end
    endtask

    task automatic end_msg();
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        msg_data  = '0;
        msg_bytes = '0;
    endtask

    task automatic wait_done(input string name, input logic expect_dv);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check({name, " queue drained"}, 512'(exp_q.size()), 512'(0));
        repeat (3) @(posedge clk);
        #1;
        check({name, " digest_valid"}, 512'(digest_valid), 512'(expect_dv));
        check({name, " busy after"}, 512'(busy), 512'(0));
    endtask

    task automatic check_all_zero(input string name);
        check({name, " msg_ready"}, 512'(msg_ready), 512'(0));
        check({name, " cmds"}, 512'({core_init, core_next, core_final}), 512'(0));
        check_block({name, " core_block"}, core_block, '0);
        check({name, " core_length"}, 512'(core_length), 512'(0));
        check({name, " digest"}, digest, '0);
        check({name, " digest_valid"}, 512'(digest_valid), 512'(0));
        check({name, " busy"}, 512'(busy), 512'(0));
    endtask

    task automatic flamingo(input logic [3:0] nbytes);
        push_ev(EV_INIT, '0, '0);
        push_ev(EV_FINAL, 128'd8, {960'b0, FLAMINGO});
        push_ev(EV_DIG, 128'd8, '0);
        send_beat(FLAMINGO, 1'b1, nbytes);
        end_msg();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("post-reset idle");

        // Single 8-byte beat.
        flamingo(4'd8);
        wait_done("flamingo", 1'b1);

        // Oversized byte count on a last beat clamps to 8.
        flamingo(4'hf);
        wait_done("flamingo clamp", 1'b1);

        // Empty message: data must be masked away.
        push_ev(EV_INIT, '0, '0);
        push_ev(EV_FINAL, 128'd0, '0);
        push_ev(EV_DIG, 128'd0, '0);
        send_beat(64'hdeadbeefdeadbeef, 1'b1, 4'd0);
        end_msg();
        wait_done("empty", 1'b1);

        // 129 bytes with a 20-cycle core stall on the non-final block.
        stall_next = 20;
        push_ev(EV_INIT, '0, '0);
        push_ev(EV_NEXT, 128'd128, full_block());
        push_ev(EV_FINAL, 128'd129, {960'b0, 64'h80});
        push_ev(EV_DIG, 128'd129, '0);
        for (int j = 0; j < 16; j++) send_beat(pat_word(j), 1'b0, 4'd3);
        send_beat(pat_word(16), 1'b1, 4'd1);
        end_msg();
        wait_done("129 bytes", 1'b1);

        // 128 bytes closed by a terminator beat.
        push_ev(EV_INIT, '0, '0);
        push_ev(EV_FINAL, 128'd128, full_block());
        push_ev(EV_DIG, 128'd128, '0);
        for (int j = 0; j < 16; j++) send_beat(pat_word(j), 1'b0, 4'd0);
        send_beat(64'hffffffffffffffff, 1'b1, 4'd0);
        end_msg();
        wait_done("128 terminator", 1'b1);

        // 128 bytes with msg_last on the 16th beat.
        push_ev(EV_INIT, '0, '0);
        push_ev(EV_FINAL, 128'd128, full_block());
        push_ev(EV_DIG, 128'd128, '0);
        for (int j = 0; j < 15; j++) send_beat(pat_word(j), 1'b0, 4'd0);
        send_beat(pat_word(15), 1'b1, 4'd8);
        end_msg();
        wait_done("128 last16", 1'b1);

        // Reset while the core is compressing.
        push_ev(EV_INIT, '0, '0);
        push_ev(EV_FINAL, 128'd8, {960'b0, FLAMINGO});
        send_beat(FLAMINGO, 1'b1, 4'd8);
        end_msg();
        begin
            int t;
            t = 0;
            while (exp_q.size() != 0 && t < 500) begin
                @(negedge clk);
                t++;
            end
            check("reset-wait queue drained", 512'(exp_q.size()), 512'(0));
        end
        @(posedge clk); #1;
        check("in WAIT before reset", 512'(busy), 512'(1));
        reset_n = 1'b0;
        #2;
        check_all_zero("reset in WAIT");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check_all_zero("after WAIT reset");

        flamingo(4'd8);
        wait_done("flamingo after reset", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/blake2b_ctrl.md
# blake2b_ctrl

Sequencing controller for the 512-bit-digest BLAKE2b core. It accepts a byte-counted message stream in 64-bit beats and packs the beats into 1024-bit blocks. It drives the core's init/next/final commands with the running byte count, then captures the 512-bit digest. It sits between the host data path and the core and owns the rule that only the last block of a message is compressed with the final flag.

## Interface
- No parameters. The digest is fixed at 64 bytes, keyed mode is not supported, and the block is fixed at 128 bytes.
- One clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- msg_valid  in  1  host beat valid.
- msg_ready  out  1  controller accepts a beat when msg_valid && msg_ready.
- msg_data  in  64  message bytes; byte i is msg_data[8i+7:8i].
- msg_last  in  1  beat is the last of the message.
- msg_bytes  in  4  valid bytes in a last beat, 0..8; ignored when msg_last=0 (non-last beats carry 8 bytes); values above 8 are treated as 8.
- core_init  out  1  one-cycle init pulse to the core.
- core_next  out  1  one-cycle pulse: compress a non-final block.
- core_final  out  1  one-cycle pulse: compress the final block.
- core_block  out  1024  block; word k is at [64k+63:64k].
- core_length  out  128  total message bytes up to and including this block.
- core_ready  in  1  core idle and able to take a command.
- core_digest  in  512  core digest.
- core_digest_valid  in  1  core digest valid.
- digest  out  512  latched digest.
- digest_valid  out  1  digest holds a result for the last completed message.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, INIT, FILL, PEND, ISSUE, WAIT, DGST.
- **IDLE**
  - msg_ready=0.
  - On msg_valid && core_ready: pulse core_init, clear the buffer, word index and byte count, clear digest_valid, go to INIT.
- **INIT**
  - Ignore core_ready for the first cycle, then wait for core_ready=1 and go to FILL.
- **FILL**
  - msg_ready=1.
  - An accepted beat is written to word[idx], idx increments, and the count adds 8 (or msg_bytes on a last beat).
  - Bytes at or above msg_bytes in a last beat are zeroed. Words not written in a block are zero.
  - Last beat: set the final flag and go to ISSUE.
  - 16th word without last: go to PEND.
- **PEND**
  - The block is full and it is not yet known whether it is the last one; msg_ready=0 except in the terminator case below.
  - Beat with msg_last=1 and msg_bytes=0: accept it (terminator), set the final flag, go to ISSUE.
  - Any other msg_valid: the beat is not accepted. Clear the final flag and go to ISSUE. After the core completes, control returns to FILL with a zeroed buffer and idx=0, and the held beat is accepted there.
- **ISSUE**
  - With core_ready=1, pulse core_final if the final flag is set, otherwise core_next.
  - core_length is the byte count; go to WAIT.
- **WAIT**
  - Ignore core_ready for the first cycle, then wait for core_ready=1.
  - After a non-final block: go to FILL.
  - After the final block: go to DGST.
- **DGST**
  - Wait for core_digest_valid, latch core_digest into digest, set digest_valid, go to IDLE.
- core_block and core_length hold stable from the command pulse until the core returns ready.
- Byte count is 128-bit and wraps modulo 2^128.
- Empty message: a single beat with msg_last=1 and msg_bytes=0 gives core_final with an all-zero block and length 0.
- digest_valid stays high until the next core_init.
- digest holds its value until it is overwritten.

## Timing
- Reset values:
  - All outputs 0, state IDLE.
  - Buffer, count and digest cleared.
  - This applies immediately on reset_n low in any state, including mid-compression. The core is reset by the same net.
- Host throughput: in FILL, one beat per cycle.
- After the 16th beat, msg_ready is 0 until the block has been compressed.
- Command pulses are exactly one cycle wide and only ever issued with core_ready=1 in the same cycle.
- Latency, final beat accepted to core_final: 1 cycle (ISSUE entered on the next edge, pulse in that cycle if core_ready).
- Latency, core_digest_valid to digest_valid: 1 cycle.
- Only one of core_init, core_next and core_final is ever high in a cycle.

## Test plan
- **"flamingo"**: one beat, msg_data[7:0]=0x66 ('f') … msg_data[63:56]=0x6f ('o'), msg_last=1, msg_bytes=8.
  - Expect core_init, then one core_final with core_length=8 and core_block[63:0] equal to the beat with the rest zero.
  - Core model returns a digest; digest_valid rises one cycle after core_digest_valid.
- **Empty message**: msg_last=1, msg_bytes=0.
  - Expect core_final with block 0 and length 0, and no core_next.
- **129 bytes**: 17 beats, last with msg_bytes=1.
  - Expect core_next with length 128, then core_final with length 129, block word 0 = that byte only, rest zero.
- **128 bytes**: 16 beats, then a terminator beat (msg_last=1, msg_bytes=0).
  - Expect no core_next and exactly one core_final with length 128 and the full block.
  - A variant ends instead with msg_last on the 16th beat; expect the same result.
- **Core stall**: core_ready held low for 20 cycles during WAIT.
  - Expect msg_ready=0, no command pulses, and core_block stable; the flow completes normally afterwards.
- **Reset in WAIT**: assert reset_n low while a block is being compressed.
  - Expect all outputs 0 and state IDLE.
  - A following "flamingo" message then produces the correct single final command with length 8.
